// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic group: default operand width and
// the state encoding used by the bit-serial subtractor.
package arith_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fsub1.sv
// Combinational full-subtractor cell: d = a - b - bin, with borrow out.
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub4bit_serial.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// o = {final borrow, x0 - x1 mod 2**WIDTH}, i.e. the signed difference.
module sub4bit_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   o
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             last;
  logic             d;
  logic             bout;

  fsub1 u_fsub1 (
    .a    (a[0]),
    .b    (b[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign last    = (count == CW'(WIDTH - 1));
  assign res_nxt = {d, res[WIDTH-1:1]};
  assign busy    = (state != IDLE);

  // FIN may reload directly so back-to-back requests lose no cycle
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = FIN;
      end
      FIN: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      o      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a      <= x0;
        b      <= x1;
        borrow <= 1'b0;
        count  <= '0;
      end else if (state == RUN) begin
        a      <= a >> 1;
        b      <= b >> 1;
        borrow <= bout;
        res    <= res_nxt;
        count  <= count + 1'b1;
        // o is only written here, so it holds across new starts
        if (last) begin
          o    <= {bout, res_nxt};
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub4bit_serial.sv
// Scoreboard bench for sub4bit_serial: stimulus queues expected results,
// a negedge monitor pops and compares them whenever done is high.
module tb_sub4bit_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] x0 = '0;
  logic [3:0] x1 = '0;
  logic       busy;
  logic       done;
  logic [4:0] o;

  logic [4:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;
  int         done_count = 0;
  int         last_done = 0;

  sub4bit_serial #(.WIDTH(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x0    (x0),
    .x1    (x1),
    .busy  (busy),
    .done  (done),
    .o     (o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && done) begin
      done_count = done_count + 1;
      last_done  = cycle;
      vectors    = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL unexpected_done: o=%b with no pending result", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          miscompares = miscompares + 1;
          $display("[TB] FAIL result: got o=%b, expected %b", o, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Waits (bounded) for done at a negedge and reports the cycle it was seen
  task automatic waitDone(output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        at   = cycle;
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] bb,
                               input logic [4:0] e, input bit chk);
    bit seen;
    int at;
    int start_cycle;
    @(posedge clk);
    #1;
    x0    = a;
    x1    = bb;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start_cycle = cycle;
    start       = 1'b0;
    waitDone(seen, at);
    @(posedge clk);
    #1;
    if (chk && seen) begin
      checkOutput("latency", at - start_cycle, 4);
      checkOutput("busy_after_done", int'(busy), 0);
    end
  endtask

  initial begin
    bit seen;
    int d1;
    int d2;
    int cnt0;
    logic [4:0] e;

    $display("[TB] starting sub4bit_serial bench");
    #12;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_o", int'(o), 0);
    #6 rst_n = 1'b1;

    applyStimulus(4'd9, 4'd6, 5'b00011, 1'b1);
    applyStimulus(4'd3, 4'd10, 5'b11001, 1'b1);
    applyStimulus(4'd0, 4'd15, 5'b10001, 1'b1);
    applyStimulus(4'd15, 4'd0, 5'b01111, 1'b1);

    // back-to-back: start held through FIN reloads with the new operands
    @(posedge clk);
    #1;
    x0 = 4'd15; x1 = 4'd15; start = 1'b1;
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00111);
    @(posedge clk);
    #1;
    x0 = 4'd8; x1 = 4'd1;
    waitDone(seen, d1);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(seen, d2);
    checkOutput("b2b_spacing", d2 - d1, 5);
    @(posedge clk);
    #1;

    // start and operand changes mid-run are ignored
    cnt0 = done_count;
    @(posedge clk);
    #1;
    x0 = 4'd12; x1 = 4'd5; start = 1'b1;
    exp_q.push_back(5'b00111);
    @(posedge clk);
    #1;
    start = 1'b0; x0 = 4'd1; x1 = 4'd14;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; x0 = 4'd0; x1 = 4'd0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("single_done", done_count - cnt0, 1);
    checkOutput("o_holds", int'(o), 7);
    checkOutput("idle_after_ignore", int'(busy), 0);

    // asynchronous reset mid-run
    @(posedge clk);
    #1;
    x0 = 4'd7; x1 = 4'd2; start = 1'b1;
    exp_q.push_back(5'b00101);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_o", int'(o), 0);
    #2;
    rst_n = 1'b1;
    cnt0 = done_count;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("no_done_after_rst", done_count - cnt0, 0);
    checkOutput("idle_after_rst", int'(busy), 0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        e = 5'(i - j);
        applyStimulus(4'(i), 4'(j), e, 1'b0);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
